// File: rtl/tetris_board_renderer.sv
// Pixel-colour source for the Tetris board: double-buffered 10x20 cell store and
// a two-stage pixel pipeline that keeps R/G/B co-aligned with the delayed syncs.
module tetris_board_renderer #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int BOARD_X0 = 240,
    parameter int BOARD_Y0 = 80,
    parameter int BORDER   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] pixel_x,
    input  logic [8:0] pixel_y,
    input  logic       video_on,
    input  logic       hs_in,
    input  logic       vs_in,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [3:0] wr_col,
    input  logic [4:0] wr_row,
    input  logic [2:0] wr_color,
    input  logic       commit,
    output logic       commit_pending,
    output logic       frame_swapped,
    output logic       R,
    output logic       G,
    output logic       B,
    output logic       hs_out,
    output logic       vs_out
);

    localparam logic [9:0] LP_HACT = 10'(H_ACTIVE);
    localparam logic [8:0] LP_VBLY = 9'(V_ACTIVE);
    localparam logic [9:0] LP_BX0  = 10'(BOARD_X0);
    localparam logic [9:0] LP_BY0  = 10'(BOARD_Y0);
    localparam logic [9:0] LP_BX1  = 10'(BOARD_X0 + 160);
    localparam logic [9:0] LP_BY1  = 10'(BOARD_Y0 + 320);
    localparam logic [9:0] LP_OX0  = 10'(BOARD_X0 - BORDER);
    localparam logic [9:0] LP_OY0  = 10'(BOARD_Y0 - BORDER);
    localparam logic [9:0] LP_OX1  = 10'(BOARD_X0 + 160 + BORDER);
    localparam logic [9:0] LP_OY1  = 10'(BOARD_Y0 + 320 + BORDER);

    logic [2:0] r_back  [20][10];
    logic [2:0] r_front [20][10];
    logic       r_pending;
    logic       r_swapped;

    logic       w_vblank_start;
    logic       w_swap;
    logic       w_wr_fire;
    logic       w_wr_in_range;

    assign w_vblank_start = (pixel_y == LP_VBLY) && (pixel_x == 10'd0);
    assign w_swap         = w_vblank_start && r_pending;
    assign w_wr_fire      = wr_valid && !r_pending;
    assign w_wr_in_range  = (wr_col <= 4'd9) && (wr_row <= 5'd19);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 20; r++) begin
                for (int c = 0; c < 10; c++) begin
                    r_back[r][c]  <= 3'd0;
                    r_front[r][c] <= 3'd0;
                end
            end
        end else begin
            // Back buffer is retained after the copy so the game can edit incrementally.
            if (w_swap)
                r_front <= r_back;
            if (w_wr_fire && w_wr_in_range)
                r_back[wr_row][wr_col] <= wr_color;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
            r_swapped <= 1'b0;
        end else begin
            r_swapped <= w_swap;
            if (w_swap)
                r_pending <= 1'b0;
            else if (commit)
                r_pending <= 1'b1;
        end
    end

    assign wr_ready       = !r_pending;
    assign commit_pending = r_pending;
    assign frame_swapped  = r_swapped;

    logic [9:0] w_x;
    logic [9:0] w_y;
    logic       w_vld;
    logic       w_in_board;
    logic       w_in_outer;
    logic [7:0] w_dx;
    logic [8:0] w_dy;

    assign w_x        = pixel_x;
    assign w_y        = {1'b0, pixel_y};
    assign w_vld      = video_on && (w_x < LP_HACT);
    assign w_in_board = w_vld && (w_x >= LP_BX0) && (w_x < LP_BX1)
                              && (w_y >= LP_BY0) && (w_y < LP_BY1);
    assign w_in_outer = w_vld && (w_x >= LP_OX0) && (w_x < LP_OX1)
                              && (w_y >= LP_OY0) && (w_y < LP_OY1);
    assign w_dx       = w_in_board ? 8'(w_x - LP_BX0) : 8'd0;
    assign w_dy       = w_in_board ? 9'(w_y - LP_BY0) : 9'd0;

    // Stage 1: region classification, cell address and gap flag
    logic       r_vld_p1;
    logic       r_in_board_p1;
    logic       r_in_border_p1;
    logic [3:0] r_col_p1;
    logic [4:0] r_row_p1;
    logic       r_gap_p1;
    logic       r_hs_p1;
    logic       r_vs_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1       <= 1'b0;
            r_in_board_p1  <= 1'b0;
            r_in_border_p1 <= 1'b0;
            r_col_p1       <= 4'd0;
            r_row_p1       <= 5'd0;
            r_gap_p1       <= 1'b0;
            r_hs_p1        <= 1'b1;
            r_vs_p1        <= 1'b1;
        end else begin
            r_vld_p1       <= w_vld;
            r_in_board_p1  <= w_in_board;
            r_in_border_p1 <= w_in_outer && !w_in_board;
            r_col_p1       <= w_dx[7:4];
            r_row_p1       <= w_dy[8:4];
            r_gap_p1       <= (&w_dx[3:0]) || (&w_dy[3:0]);
            r_hs_p1        <= hs_in;
            r_vs_p1        <= vs_in;
        end
    end

    logic [2:0] w_cell;
    logic [2:0] w_rgb;

    assign w_cell = r_front[r_row_p1][r_col_p1];

    always_comb begin
        w_rgb = 3'b000;
        if (r_vld_p1) begin
            if (r_in_board_p1 && !r_gap_p1)
                w_rgb = w_cell;
            else if (r_in_border_p1)
                w_rgb = 3'b111;
        end
    end

    // Stage 2: registered colour and syncs
    logic [2:0] r_rgb_p2;
    logic       r_hs_p2;
    logic       r_vs_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb_p2 <= 3'b000;
            r_hs_p2  <= 1'b1;
            r_vs_p2  <= 1'b1;
        end else begin
            r_rgb_p2 <= w_rgb;
            r_hs_p2  <= r_hs_p1;
            r_vs_p2  <= r_vs_p1;
        end
    end

    assign R      = r_rgb_p2[2];
    assign G      = r_rgb_p2[1];
    assign B      = r_rgb_p2[0];
    assign hs_out = r_hs_p2;
    assign vs_out = r_vs_p2;

endmodule

// File: tb/tb_tetris_board_renderer.sv
// Bench for tetris_board_renderer: random coordinates, writes and commits checked
// against a cell-array reference model, plus directed board/commit/reset scenarios.
module tb_tetris_board_renderer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] pixel_x;
    logic [8:0] pixel_y;
    logic       video_on;
    logic       hs_in;
    logic       vs_in;
    logic       wr_valid;
    logic       wr_ready;
    logic [3:0] wr_col;
    logic [4:0] wr_row;
    logic [2:0] wr_color;
    logic       commit;
    logic       commit_pending;
    logic       frame_swapped;
    logic       R;
    logic       G;
    logic       B;
    logic       hs_out;
    logic       vs_out;

    always #5 clk = ~clk;

    tetris_board_renderer dut (
        .clk(clk), .rst_n(rst_n),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
        .hs_in(hs_in), .vs_in(vs_in),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_col(wr_col), .wr_row(wr_row), .wr_color(wr_color),
        .commit(commit), .commit_pending(commit_pending), .frame_swapped(frame_swapped),
        .R(R), .G(G), .B(B), .hs_out(hs_out), .vs_out(vs_out)
    );

    typedef struct {
        logic [2:0] rgb;
        logic       hs;
        logic       vs;
    } exp_t;

    logic [2:0] m_back  [20][10];
    logic [2:0] m_front [20][10];
    logic       m_pend;
    logic       m_swp;
    exp_t       pipe [2];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2:0] ref_pixel(input int x, input int y);
        int c;
        int r;
        if (!(x < 640 && y < 480)) return 3'b000;
        if (x >= 240 && x < 400 && y >= 80 && y < 400) begin
            c = (x - 240) / 16;
            r = (y - 80) / 16;
            if ((x - 240) % 16 == 15 || (y - 80) % 16 == 15) return 3'b000;
            return m_front[r][c];
        end
        if (x >= 236 && x < 404 && y >= 76 && y < 404) return 3'b111;
        return 3'b000;
    endfunction

    function automatic exp_t idle_exp();
        exp_t e;
        e.rgb = 3'b000;
        e.hs  = 1'b1;
        e.vs  = 1'b1;
        return e;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 10; c++) begin
                m_back[r][c]  = 3'b000;
                m_front[r][c] = 3'b000;
            end
        m_pend  = 1'b0;
        m_swp   = 1'b0;
        pipe[0] = idle_exp();
        pipe[1] = idle_exp();
    endtask

    task automatic drive_idle();
        pixel_x  = 10'd700;
        pixel_y  = 9'd500;
        video_on = 1'b0;
        hs_in    = 1'b1;
        vs_in    = 1'b1;
        wr_valid = 1'b0;
        wr_col   = 4'd0;
        wr_row   = 5'd0;
        wr_color = 3'd0;
        commit   = 1'b0;
    endtask

    // One clock: check outputs against the model, then present new inputs and advance the model.
    task automatic cycle(input int x, input int y, input bit wv, input int col,
                         input int row, input int color, input bit cm);
        logic old;
        exp_t e;
        @(posedge clk);
        #1;
        chk("rgb", 32'({R, G, B}), 32'(pipe[0].rgb));
        chk("hs_out", 32'(hs_out), 32'(pipe[0].hs));
        chk("vs_out", 32'(vs_out), 32'(pipe[0].vs));
        chk("wr_ready", 32'(wr_ready), 32'(!m_pend));
        chk("commit_pending", 32'(commit_pending), 32'(m_pend));
        chk("frame_swapped", 32'(frame_swapped), 32'(m_swp));
        pixel_x  = 10'(x);
        pixel_y  = 9'(y);
        video_on = (x < 640) && (y < 480);
        hs_in    = 1'($urandom);
        vs_in    = 1'($urandom);
        wr_valid = wv;
        wr_col   = 4'(col);
        wr_row   = 5'(row);
        wr_color = 3'(color);
        commit   = cm;
        old   = m_pend;
        m_swp = 1'b0;
        if (x == 0 && y == 480 && old) begin
            m_front = m_back;
            m_pend  = 1'b0;
            m_swp   = 1'b1;
        end
        if (wv && !old && col < 10 && row < 20) m_back[row][col] = 3'(color);
        if (cm && !old) m_pend = 1'b1;
        e.rgb   = ref_pixel(x, y);
        e.hs    = hs_in;
        e.vs    = vs_in;
        pipe[0] = pipe[1];
        pipe[1] = e;
    endtask

    task automatic idle_cyc();
        cycle(700, 500, 0, 0, 0, 0, 0);
    endtask

    task automatic do_write(input int col, input int row, input int color, input bit cm);
        cycle(700, 500, 1, col, row, color, cm);
    endtask

    task automatic do_vblank(input bit cm);
        cycle(0, 480, 0, 0, 0, 0, cm);
    endtask

    task automatic do_commit();
        cycle(700, 500, 0, 0, 0, 0, 1);
    endtask

    task automatic probe(input string tag, input int x, input int y, input logic [2:0] exp);
        cycle(x, y, 0, 0, 0, 0, 0);
        idle_cyc();
        idle_cyc();
        chk(tag, 32'({R, G, B}), 32'(exp));
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_rgb", 32'({R, G, B}), 32'(3'b000));
        chk("rst_hs", 32'(hs_out), 32'(1'b1));
        chk("rst_vs", 32'(vs_out), 32'(1'b1));
        chk("rst_pending", 32'(commit_pending), 32'(1'b0));
        chk("rst_ready", 32'(wr_ready), 32'(1'b1));
        chk("rst_swapped", 32'(frame_swapped), 32'(1'b0));
        drive_idle();
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int rnd;
        int x;
        int y;
        int swaps;
        rst_n = 1'b1;
        drive_idle();
        model_clear();
        #2;
        apply_reset();

        // Empty board: border ring white, interior and outside black.
        probe("border_tl", 236, 76, 3'b111);
        probe("border_left", 239, 200, 3'b111);
        probe("empty_cell", 240, 80, 3'b000);
        probe("border_br", 403, 403, 3'b111);
        probe("outside_right", 404, 200, 3'b000);
        probe("outside_top", 300, 75, 3'b000);

        // Write with commit in the same cycle; writes stall while pending.
        do_write(0, 0, 4, 1);
        idle_cyc();
        do_write(5, 5, 2, 0);
        idle_cyc();
        probe("no_tear", 240, 80, 3'b000);
        do_vblank(0);
        idle_cyc();
        probe("red_tl", 240, 80, 3'b100);
        probe("red_br", 254, 94, 3'b100);
        probe("gap_x", 255, 80, 3'b000);
        probe("gap_y", 240, 95, 3'b000);
        probe("stalled_write", 320, 160, 3'b000);

        // Uncommitted write stays invisible across frames.
        do_write(9, 19, 3, 0);
        do_vblank(0);
        probe("uncommitted", 384, 384, 3'b000);
        do_commit();
        do_vblank(0);
        probe("cyan_tl", 384, 384, 3'b011);
        probe("cyan_br", 398, 398, 3'b011);
        probe("cyan_gap", 399, 398, 3'b000);

        // Out-of-range write is accepted and dropped.
        do_write(12, 3, 7, 0);
        do_write(1, 25, 7, 0);
        do_commit();
        do_vblank(0);
        probe("oor_a", 272, 144, 3'b000);
        probe("oor_b", 272, 128, 3'b000);

        // Commit on the vblank_start cycle waits a frame; a repeat commit yields one swap.
        do_write(2, 2, 5, 0);
        do_vblank(1);
        idle_cyc();
        probe("late_commit", 272, 112, 3'b000);
        do_commit();
        swaps = 0;
        do_vblank(0);
        idle_cyc();
        swaps += int'(frame_swapped);
        idle_cyc();
        swaps += int'(frame_swapped);
        do_vblank(0);
        idle_cyc();
        swaps += int'(frame_swapped);
        chk("single_swap", 32'(swaps), 32'd1);
        probe("late_commit_shown", 272, 112, 3'b101);

        // Randomised traffic.
        for (int i = 0; i < 15000; i++) begin
            rnd = $urandom_range(0, 99);
            if (rnd < 2) begin
                x = 0;
                y = 480;
            end else if (rnd < 70) begin
                x = $urandom_range(228, 412);
                y = $urandom_range(68, 412);
            end else begin
                x = $urandom_range(0, 799);
                y = $urandom_range(0, 511);
            end
            cycle(x, y, ($urandom_range(0, 3) == 0), $urandom_range(0, 11),
                  $urandom_range(0, 21), $urandom_range(0, 7), ($urandom_range(0, 39) == 0));
        end

        // Reset mid-line with a commit pending.
        do_write(0, 0, 6, 1);
        cycle(300, 200, 0, 0, 0, 0, 0);
        cycle(310, 200, 0, 0, 0, 0, 0);
        apply_reset();
        idle_cyc();
        idle_cyc();
        do_vblank(0);
        idle_cyc();
        probe("post_reset_cell", 240, 80, 3'b000);
        probe("post_reset_border", 236, 76, 3'b111);
        for (int i = 0; i < 200; i++)
            cycle($urandom_range(228, 412), $urandom_range(68, 412), 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
